// File: rtl/io_bus_arbiter_if.sv
// Purpose: bundles the per-core request lanes, the shared I/O bus master
//          signals and the broadcast response of the I/O bus arbiter.
// Ports:   master = arbiter side (drives acks, bus strobes, responses);
//          slave  = core queues / bus device side (drives requests, read data).
interface io_bus_arbiter_if #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int THREAD_IDX_WIDTH = 2
);
  // Per-core request lanes
  logic [NUM_REQUESTERS-1:0]                       req_valid;
  logic [NUM_REQUESTERS-1:0]                       req_store;
  logic [NUM_REQUESTERS-1:0][THREAD_IDX_WIDTH-1:0] req_thread_idx;
  logic [NUM_REQUESTERS-1:0][31:0]                 req_address;
  logic [NUM_REQUESTERS-1:0][31:0]                 req_value;
  logic [NUM_REQUESTERS-1:0]                       req_ack;

  // Shared I/O bus
  logic                                            io_write_en;
  logic                                            io_read_en;
  logic [31:0]                                     io_address;
  logic [31:0]                                     io_write_data;
  logic [31:0]                                     io_read_data;

  // Broadcast response
  logic                                            rsp_valid;
  logic [3:0]                                      rsp_core;
  logic                                            rsp_store;
  logic [THREAD_IDX_WIDTH-1:0]                     rsp_thread_idx;
  logic [31:0]                                     rsp_read_value;

  modport master (
    input  req_valid, req_store, req_thread_idx, req_address, req_value,
    input  io_read_data,
    output req_ack,
    output io_write_en, io_read_en, io_address, io_write_data,
    output rsp_valid, rsp_core, rsp_store, rsp_thread_idx, rsp_read_value
  );

  modport slave (
    output req_valid, req_store, req_thread_idx, req_address, req_value,
    output io_read_data,
    input  req_ack,
    input  io_write_en, io_read_en, io_address, io_write_data,
    input  rsp_valid, rsp_core, rsp_store, rsp_thread_idx, rsp_read_value
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Purpose: round-robin arbiter sharing one non-cached I/O bus master between cores.
// Latency: ack + bus strobe 1 cycle after arbitration, response 3 cycles after; 1 txn / 3 cycles.
// Backpressure: requesters hold req_valid until req_ack; responses are broadcast with no backpressure.
// Ports:   clk, reset (synchronous, active-high); bus = io_bus_arbiter_if.master
//          carrying request lanes/req_ack, bus strobes/address/data, and rsp_* broadcast.
module io_bus_arbiter #(
  parameter int NUM_REQUESTERS   = 4,
  parameter int THREAD_IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  io_bus_arbiter_if.master     bus
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;

  logic [PTR_W-1:0]              r_ptr;
  logic [3:0]                    r_core;
  logic                          r_store;
  logic [THREAD_IDX_WIDTH-1:0]   r_thread;

  logic [NUM_REQUESTERS-1:0]     r_req_ack;
  logic                          r_io_write_en;
  logic                          r_io_read_en;
  logic [31:0]                   r_io_address;
  logic [31:0]                   r_io_write_data;
  logic                          r_rsp_valid;
  logic [3:0]                    r_rsp_core;
  logic                          r_rsp_store;
  logic [THREAD_IDX_WIDTH-1:0]   r_rsp_thread_idx;
  logic [31:0]                   r_rsp_read_value;

  logic                          w_any;
  logic                          w_hi_any;
  logic [PTR_W-1:0]              w_hi_idx;
  logic [PTR_W-1:0]              w_lo_idx;
  logic [PTR_W-1:0]              w_winner;
  logic [PTR_W-1:0]              w_ptr_next;

  // Round-robin pick without a modulo: the lowest requester at or above the
  // pointer wins; if there is none, the search has wrapped, so the lowest
  // requester overall wins.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_lo_idx = PTR_W'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_idx = PTR_W'(i);
        end
      end
    end
    w_any    = |bus.req_valid;
    w_winner = w_hi_any ? w_hi_idx : w_lo_idx;
  end

  // Just-granted requester drops to lowest priority.
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQUESTERS - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_next_state = ST_BUS;
      ST_BUS:  w_next_state = ST_DATA;
      ST_DATA: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_ptr            <= '0;
      r_core           <= '0;
      r_store          <= 1'b0;
      r_thread         <= '0;
      r_req_ack        <= '0;
      r_io_write_en    <= 1'b0;
      r_io_read_en     <= 1'b0;
      r_io_address     <= '0;
      r_io_write_data  <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_core       <= '0;
      r_rsp_store      <= 1'b0;
      r_rsp_thread_idx <= '0;
      r_rsp_read_value <= '0;
    end else begin
      r_state       <= w_next_state;
      // Pulse outputs fall back to 0 unless set below.
      r_req_ack     <= '0;
      r_io_write_en <= 1'b0;
      r_io_read_en  <= 1'b0;
      r_rsp_valid   <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ptr               <= w_ptr_next;
            r_core              <= 4'(w_winner);
            r_store             <= bus.req_store[w_winner];
            r_thread            <= bus.req_thread_idx[w_winner];
            r_req_ack[w_winner] <= 1'b1;
            // Bus cycle is launched together with the ack, so the strobe,
            // address and data registers double as the request latch.
            r_io_write_en       <= bus.req_store[w_winner];
            r_io_read_en        <= ~bus.req_store[w_winner];
            r_io_address        <= bus.req_address[w_winner];
            r_io_write_data     <= bus.req_store[w_winner] ? bus.req_value[w_winner] : 32'd0;
          end
        end
        ST_DATA: begin
          // Device returns load data during this cycle.
          r_rsp_valid      <= 1'b1;
          r_rsp_core       <= r_core;
          r_rsp_store      <= r_store;
          r_rsp_thread_idx <= r_thread;
          r_rsp_read_value <= r_store ? 32'd0 : bus.io_read_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ack        = r_req_ack;
  assign bus.io_write_en    = r_io_write_en;
  assign bus.io_read_en     = r_io_read_en;
  assign bus.io_address     = r_io_address;
  assign bus.io_write_data  = r_io_write_data;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_core       = r_rsp_core;
  assign bus.rsp_store      = r_rsp_store;
  assign bus.rsp_thread_idx = r_rsp_thread_idx;
  assign bus.rsp_read_value = r_rsp_read_value;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Purpose: randomized + directed bench for io_bus_arbiter against a
//          transaction-level timing/round-robin reference model.
// Ports:   none (top-level bench).
module tb_io_bus_arbiter;
  localparam int NR = 4;
  localparam int TW = 2;

  typedef struct {
    bit          store;
    bit [TW-1:0] thr;
    bit [31:0]   addr;
    bit [31:0]   val;
    bit [31:0]   dev;   // data the bus device returns if this is a read
  } pkt_t;

  logic clk;
  logic reset;

  io_bus_arbiter_if #(.NUM_REQUESTERS(NR), .THREAD_IDX_WIDTH(TW)) bus_if ();

  io_bus_arbiter #(.NUM_REQUESTERS(NR), .THREAD_IDX_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pending requests per core; head is what the core presents.
  pkt_t q [NR][$];
  int   grant_log [$];
  int   gcyc_log  [$];

  // Expected outputs per cycle, indexed by cycle number mod 8.
  logic [NR-1:0] e_ack  [8];
  bit            e_rd   [8];
  bit            e_wr   [8];
  bit            e_rsp  [8];
  bit            e_zero [8];
  logic [31:0]   e_addr [8];
  logic [31:0]   e_wdat [8];
  logic [31:0]   e_rval [8];
  logic [3:0]    e_core [8];
  logic [TW-1:0] e_thr  [8];
  bit            e_st   [8];

  int        cyc        = 0;
  int        m_ptr      = 0;
  int        m_idle_at  = 0;
  int        m_data_cyc = -1;
  bit [31:0] m_data_val = 0;
  bit        rst_req    = 1'b1;
  bit        rand_mode  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cycle %0d: got 0x%h expected 0x%h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  function automatic void clr_slot(input int s);
    e_ack[s]  = '0;  e_rd[s] = 1'b0; e_wr[s] = 1'b0; e_rsp[s] = 1'b0;
    e_zero[s] = 1'b0; e_addr[s] = '0; e_wdat[s] = '0; e_rval[s] = '0;
    e_core[s] = '0;  e_thr[s] = '0;  e_st[s] = 1'b0;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.store = 1'($urandom_range(0, 1));
    p.thr   = TW'($urandom_range(0, (1 << TW) - 1));
    p.addr  = $urandom();
    p.val   = $urandom();
    p.dev   = $urandom();
    return p;
  endfunction

  function automatic pkt_t mk(input bit st, input int thr, input bit [31:0] a,
                              input bit [31:0] v, input bit [31:0] d);
    pkt_t p;
    p.store = st; p.thr = TW'(thr); p.addr = a; p.val = v; p.dev = d;
    return p;
  endfunction

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int gcyc_at(input int i);
    return (i < gcyc_log.size()) ? gcyc_log[i] : -100;
  endfunction

  function automatic bit busy();
    bit b = (cyc < m_idle_at);
    for (int i = 0; i < NR; i++) if (q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // One clock cycle: check this cycle's outputs, play the cores and the bus
  // device, then predict what the arbiter must do with the new inputs.
  task automatic step();
    int   s;
    int   w;
    int   idx;
    pkt_t p;
    @(negedge clk);
    cyc++;
    s = cyc % 8;
    check("req_ack",     32'(bus_if.req_ack),     32'(e_ack[s]));
    check("io_read_en",  32'(bus_if.io_read_en),  32'(e_rd[s]));
    check("io_write_en", 32'(bus_if.io_write_en), 32'(e_wr[s]));
    check("rsp_valid",   32'(bus_if.rsp_valid),   32'(e_rsp[s]));
    if (e_rd[s] || e_wr[s]) begin
      check("io_address",    bus_if.io_address,    e_addr[s]);
      check("io_write_data", bus_if.io_write_data, e_wdat[s]);
    end
    if (e_rsp[s]) begin
      check("rsp_core",       32'(bus_if.rsp_core),       32'(e_core[s]));
      check("rsp_thread_idx", 32'(bus_if.rsp_thread_idx), 32'(e_thr[s]));
      check("rsp_store",      32'(bus_if.rsp_store),      32'(e_st[s]));
      check("rsp_read_value", bus_if.rsp_read_value,      e_rval[s]);
    end
    if (e_zero[s]) begin
      check("rst_io_address",    bus_if.io_address,           32'd0);
      check("rst_io_write_data", bus_if.io_write_data,        32'd0);
      check("rst_rsp_core",      32'(bus_if.rsp_core),        32'd0);
      check("rst_rsp_thread",    32'(bus_if.rsp_thread_idx),  32'd0);
      check("rst_rsp_store",     32'(bus_if.rsp_store),       32'd0);
      check("rst_rsp_value",     bus_if.rsp_read_value,       32'd0);
    end
    clr_slot(s);

    // Cores: an acked request is retired and the next one presented.
    for (int i = 0; i < NR; i++) begin
      if (bus_if.req_ack[i] === 1'b1) begin
        grant_log.push_back(i);
        gcyc_log.push_back(cyc);
        if (q[i].size() > 0) q[i].delete(0);
      end
    end
    if (rand_mode)
      for (int i = 0; i < NR; i++)
        if (q[i].size() < 2 && $urandom_range(0, 2) == 0) q[i].push_back(rand_pkt());
    for (int i = 0; i < NR; i++) begin
      p = (q[i].size() > 0) ? q[i][0] : rand_pkt();
      bus_if.req_valid[i]      = (q[i].size() > 0);
      bus_if.req_store[i]      = p.store;
      bus_if.req_thread_idx[i] = p.thr;
      bus_if.req_address[i]    = p.addr;
      bus_if.req_value[i]      = p.val;
    end
    reset = rst_req;

    // Bus device: load data only matters in the cycle after the read strobe.
    bus_if.io_read_data = (cyc == m_data_cyc) ? m_data_val : $urandom();

    if (rst_req) begin
      for (int j = 0; j < 8; j++) clr_slot(j);
      e_zero[(cyc + 1) % 8] = 1'b1;
      m_ptr      = 0;
      m_idle_at  = cyc + 1;
      m_data_cyc = -1;
    end else if (cyc >= m_idle_at) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (w < 0 && q[idx].size() > 0) w = idx;
      end
      if (w >= 0) begin
        p = q[w][0];
        s = (cyc + 1) % 8;
        e_ack[s][w] = 1'b1;
        e_rd[s]     = !p.store;
        e_wr[s]     = p.store;
        e_addr[s]   = p.addr;
        e_wdat[s]   = p.store ? p.val : 32'd0;
        s = (cyc + 3) % 8;
        e_rsp[s]    = 1'b1;
        e_core[s]   = 4'(w);
        e_thr[s]    = p.thr;
        e_st[s]     = p.store;
        e_rval[s]   = p.store ? 32'd0 : p.dev;
        m_ptr       = (w + 1) % NR;
        m_idle_at   = cyc + 3;
        m_data_cyc  = cyc + 2;
        m_data_val  = p.dev;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(busy()), 32'd0);
  endtask

  initial begin
    for (int j = 0; j < 8; j++) clr_slot(j);
    reset = 1'b1;
    bus_if.req_valid      = '0;
    bus_if.req_store      = '0;
    bus_if.req_thread_idx = '0;
    bus_if.req_address    = '0;
    bus_if.req_value      = '0;
    bus_if.io_read_data   = '0;

    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();

    // Single read from core 0.
    grant_log.delete();
    q[0].push_back(mk(1'b0, 2, 32'h10, 32'h5555_AAAA, 32'hDEAD_BEEF));
    drain(30);
    check("read_grant", 32'(log_at(0)), 32'd0);

    // Single write from core 2.
    grant_log.delete();
    q[2].push_back(mk(1'b1, 1, 32'h20, 32'h1234, 32'hFFFF_FFFF));
    drain(30);
    check("write_grant", 32'(log_at(0)), 32'd2);

    // Quiet bus: per-cycle checks require all pulses to stay low.
    repeat (10) step();

    // Fresh pointer, then cores 0, 1, 3 request together.
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    grant_log.delete();
    gcyc_log.delete();
    q[0].push_back(rand_pkt());
    q[1].push_back(rand_pkt());
    q[3].push_back(rand_pkt());
    drain(40);
    check("rr3_grant0", 32'(log_at(0)), 32'd0);
    check("rr3_grant1", 32'(log_at(1)), 32'd1);
    check("rr3_grant2", 32'(log_at(2)), 32'd3);
    check("rr3_space01", 32'(gcyc_at(1) - gcyc_at(0)), 32'd3);
    check("rr3_space12", 32'(gcyc_at(2) - gcyc_at(1)), 32'd3);

    // Cores 0 and 1 continuously requesting: must alternate.
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      q[0].push_back(rand_pkt());
      q[1].push_back(rand_pkt());
    end
    drain(60);
    for (int k = 0; k < 8; k++) check("alt_grant", 32'(log_at(k)), 32'(k % 2));

    // Reset while a read from core 1 is on the bus; pointer must return to 0.
    grant_log.delete();
    q[1].push_back(mk(1'b0, 3, 32'h40, 32'h0, 32'hCAFE_F00D));
    for (int k = 0; k < 10 && grant_log.size() == 0; k++) step();
    check("mid_rst_grant", 32'(log_at(0)), 32'd1);
    rst_req = 1'b1;
    q[0].push_back(rand_pkt());
    q[2].push_back(rand_pkt());
    step();
    rst_req = 1'b0;
    grant_log.delete();
    drain(40);
    check("post_rst_first", 32'(log_at(0)), 32'd0);
    check("post_rst_second", 32'(log_at(1)), 32'd2);

    // Random traffic with occasional resets.
    rand_mode = 1'b1;
    for (int k = 0; k < 800; k++) begin
      rst_req = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_req   = 1'b0;
    rand_mode = 1'b0;
    drain(100);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
